// File: rtl/march_gen.sv
// March C- address/data sequencer and read comparator for the memory BIST.
// Define BIST_DIAG_EN to build the first-mismatch address/element capture.
module march_gen #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              NbarT,
  input  logic [DATA_W-1:0] q_in,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              we,
  output logic              re,
  output logic              cout,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  localparam int unsigned ELEM_W = 3;
  localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(5);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [ELEM_W-1:0]   elem_q, elem_d, next_elem;
  logic                op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cout_q, cout_d;

  logic issue, desc, is_read, last_op, addr_end, read_one, write_one, start_op;
  logic cmp_pend_q, cmp_one_q, fail_q, mismatch_now;

  // Element decode: elements 3 and 4 descend; elements 0 and 5 have a single op.
  assign issue     = (state_q == RUN) && NbarT && !ld;
  assign desc      = (elem_q == ELEM_W'(3)) || (elem_q == ELEM_W'(4));
  assign is_read   = (elem_q != ELEM_W'(0)) && !op_q;
  assign last_op   = (elem_q == ELEM_W'(0)) || (elem_q == LAST_ELEM) || op_q;
  assign addr_end  = desc ? (addr_q == '0) : (addr_q == '1);
  assign read_one  = (elem_q == ELEM_W'(2)) || (elem_q == ELEM_W'(4));
  assign write_one = (elem_q == ELEM_W'(1)) || (elem_q == ELEM_W'(3));
  assign start_op  = issue && (elem_q == '0) && (addr_q == '0) && !op_q;
  assign next_elem = elem_q + ELEM_W'(1);

  assign addr  = issue ? addr_q : '0;
  assign we    = issue && !is_read;
  assign re    = issue && is_read;
  assign wdata = (issue && !is_read && write_one) ? '1 : '0;
  assign cout  = cout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      elem_q  <= '0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      cout_q  <= cout_d;
    end
  end

  // Sequencing: op advances first, then address, then element.
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    op_d    = op_q;
    addr_d  = addr_q;
    cout_d  = 1'b0;
    if (ld) begin
      state_d = RUN;
      elem_d  = '0;
      op_d    = 1'b0;
      addr_d  = '0;
    end else if (issue) begin
      if (!last_op) begin
        op_d = 1'b1;
      end else begin
        op_d = 1'b0;
        if (!addr_end) begin
          addr_d = desc ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
        end else if (elem_q == LAST_ELEM) begin
          state_d = DONE;
          cout_d  = 1'b1;
        end else begin
          elem_d = next_elem;
          addr_d = ((next_elem == ELEM_W'(3)) || (next_elem == ELEM_W'(4))) ? '1 : '0;
        end
      end
    end
  end

  // The final read is compared in the cout cycle, so the live mismatch is folded into fail.
  assign mismatch_now = cmp_pend_q && (q_in != {DATA_W{cmp_one_q}});
  assign fail         = fail_q || mismatch_now;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_pend_q <= 1'b0;
      cmp_one_q  <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      cmp_pend_q <= re;
      if (re) cmp_one_q <= read_one;
      if (mismatch_now)  fail_q <= 1'b1;
      else if (start_op) fail_q <= 1'b0;
    end
  end

`ifdef BIST_DIAG_EN
  logic [ADDR_W-1:0] cmp_addr_q, diag_addr_q;
  logic [ELEM_W-1:0] cmp_elem_q, diag_elem_q;
  logic              capture_now;

  assign capture_now = mismatch_now && !fail_q;
  assign fail_addr   = capture_now ? cmp_addr_q : diag_addr_q;
  assign fail_elem   = capture_now ? cmp_elem_q : diag_elem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_addr_q  <= '0;
      cmp_elem_q  <= '0;
      diag_addr_q <= '0;
      diag_elem_q <= '0;
    end else begin
      if (re) begin
        cmp_addr_q <= addr_q;
        cmp_elem_q <= elem_q;
      end
      if (capture_now) begin
        diag_addr_q <= cmp_addr_q;
        diag_elem_q <= cmp_elem_q;
      end else if (start_op) begin
        diag_addr_q <= '0;
        diag_elem_q <= '0;
      end
    end
  end
`else
  assign fail_addr = '0;
  assign fail_elem = '0;
`endif

endmodule

// File: tb/tb_march_gen.sv
// Scoreboard bench for march_gen: random faults and pauses against a March C- reference model.
module tb_march_gen;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned N      = 4;
  localparam int unsigned NOPS   = 10 * N;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ld = 1'b0;
  logic              nbart = 1'b0;
  logic [DATA_W-1:0] q_in = '0;
  logic [ADDR_W-1:0] addr, fail_addr;
  logic [DATA_W-1:0] wdata;
  logic              we, re, cout, fail;
  logic [2:0]        fail_elem;

  march_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .ld(ld), .NbarT(nbart), .q_in(q_in),
    .addr(addr), .wdata(wdata), .we(we), .re(re), .cout(cout),
    .fail(fail), .fail_addr(fail_addr), .fail_elem(fail_elem)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [2:0]        e;
  } op_t;

  op_t               exp_q[$];
  logic [DATA_W-1:0] mem [N];
  bit                f_en, f_val;
  int                f_addr, f_bit;
  bit                exp_fail;
  int                exp_faddr, exp_felem;
  int                last_fail = 0;
  int                n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Faulty cell model: one bit of one word stuck at f_val.
  function automatic logic [DATA_W-1:0] stored(input int a, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] m;
    m = DATA_W'(1) << f_bit;
    if (f_en && a == f_addr) return f_val ? (d | m) : (d & ~m);
    return d;
  endfunction

  // Behavioural memory, 1-cycle read latency.
  always @(posedge clk) begin
    if (we) mem[addr] <= stored(int'(addr), wdata);
    if (re) q_in <= mem[addr];
  end

  // Reference: expand March C- into an op list and predict the first mismatch.
  function automatic void push_run();
    logic [DATA_W-1:0] mm [N];
    op_t      o;
    int       n, a;
    bit [1:0] w, v;
    exp_q.delete();
    exp_fail = 0; exp_faddr = 0; exp_felem = 0;
    for (int e = 0; e < 6; e++) begin
      case (e)
        0:       begin n = 1; w = 2'b01; v = 2'b00; end
        1, 3:    begin n = 2; w = 2'b10; v = 2'b10; end
        2, 4:    begin n = 2; w = 2'b10; v = 2'b01; end
        default: begin n = 1; w = 2'b00; v = 2'b00; end
      endcase
      for (int i = 0; i < int'(N); i++) begin
        a = (e == 3 || e == 4) ? int'(N) - 1 - i : i;
        for (int k = 0; k < n; k++) begin
          o.w = w[k];
          o.a = ADDR_W'(a);
          o.d = v[k] ? '1 : '0;
          o.e = 3'(e);
          exp_q.push_back(o);
          if (w[k]) mm[a] = stored(a, o.d);
          else if (mm[a] !== o.d && !exp_fail) begin
            exp_fail = 1; exp_faddr = a; exp_felem = e;
          end
        end
      end
    end
  endfunction

  // Monitor: every strobe is popped against the scoreboard.
  always @(negedge clk) begin
    op_t o;
    if (rst && (we || re)) begin
      if (exp_q.size() == 0) check("unexpected_op", 32'({we, re, addr}), 32'd0);
      else begin
        o = exp_q.pop_front();
        check("op_kind", 32'({we, re}), 32'({o.w, !o.w}));
        check("op_addr", 32'(addr), 32'(o.a));
        if (o.w) check("op_wdata", 32'(wdata), 32'(o.d));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    int prev;
    prev = last_fail;
    push_run();
    ld = 1'b1;
    nbart = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("ld_no_strobe", 32'({we, re}), 32'd0);
    if (prev >= 0) check("fail_hold_ld", 32'(fail), 32'(prev));
    cyc();
    ld = 1'b0;
  endtask

  task automatic drive_ops(input int n, input int p_at, input int p_len, input bit rnd);
    int issued, len;
    issued = 0;
    while (issued < n) begin
      len = 0;
      if (issued == p_at) len = p_len;
      else if (rnd && $urandom_range(0, 9) == 0) len = $urandom_range(1, 3);
      repeat (len) begin
        nbart = 1'b0;
        @(negedge clk);
        check("pause_strobe", 32'({we, re}), 32'd0);
        cyc();
      end
      nbart = 1'b1;
      cyc();
      issued++;
    end
  endtask

  task automatic finish_run();
    @(negedge clk);
    check("cout_rise", 32'(cout), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("fail_at_cout", 32'(fail), 32'(exp_fail));
`ifdef BIST_DIAG_EN
    if (exp_fail) begin
      check("fail_addr", 32'(fail_addr), 32'(exp_faddr));
      check("fail_elem", 32'(fail_elem), 32'(exp_felem));
    end
`else
    check("fail_addr_tied", 32'(fail_addr), 32'd0);
    check("fail_elem_tied", 32'(fail_elem), 32'd0);
`endif
    nbart = 1'($urandom_range(0, 1));
    cyc();
    @(negedge clk);
    check("cout_fall", 32'(cout), 32'd0);
    check("done_no_strobe", 32'({we, re}), 32'd0);
    check("fail_persist", 32'(fail), 32'(exp_fail));
    cyc();
    last_fail = exp_fail;
  endtask

  initial begin
    for (int i = 0; i < int'(N); i++) mem[i] = DATA_W'($urandom);
    f_en = 0; f_val = 0; f_addr = 0; f_bit = 0;
    nbart = 1'b1;
    #2;
    check("rst_outputs", 32'({addr, wdata, we, re, cout, fail, fail_addr, fail_elem}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_no_op", 32'({we, re}), 32'd0);
    end
    cyc();

    // Fault-free directed run.
    start_run(); drive_ops(NOPS, -1, 0, 0); finish_run();

    // Stuck-at-0 on bit 3 of word 2.
    f_en = 1; f_addr = 2; f_bit = 3; f_val = 0;
    start_run(); drive_ops(NOPS, -1, 0, 0); finish_run();

    // Clean run after a failing one: fail must survive ld, then clear.
    f_en = 0;
    start_run(); drive_ops(NOPS, -1, 0, 0); finish_run();

    // Pause five cycles at operation 13.
    start_run(); drive_ops(NOPS, 13, 5, 0); finish_run();

    // Random faults and random pauses.
    for (int r = 0; r < 6; r++) begin
      f_en   = 1'($urandom_range(0, 1));
      f_addr = $urandom_range(0, N - 1);
      f_bit  = $urandom_range(0, DATA_W - 1);
      f_val  = 1'($urandom_range(0, 1));
      start_run(); drive_ops(NOPS, -1, 0, 1); finish_run();
    end

    // Async reset inside element 3, between clock edges.
    f_en = 1; f_addr = $urandom_range(0, N - 1); f_bit = 0; f_val = 1;
    start_run();
    drive_ops(21 + $urandom_range(0, 6), -1, 0, 0);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_run", 32'({addr, wdata, we, re, cout, fail, fail_addr, fail_elem}), 32'd0);
    exp_q.delete();
    last_fail = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_idle", 32'({we, re}), 32'd0);
    end
    cyc();

    // ld inside element 4 restarts the sequence.
    f_en = 0;
    start_run();
    drive_ops(29 + $urandom_range(0, 6), -1, 0, 0);
    last_fail = -1;
    start_run(); drive_ops(NOPS, -1, 0, 1); finish_run();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/march_gen.md
# march_gen

March C- address/data sequencer and read comparator for the memory BIST. It sits directly downstream of the BIST controller and consumes its `ld` (load/arm) and `NbarT` (test-mode) outputs. It drives the memory under test's address, write data and read/write strobes, checks read data against expected values, and returns `cout` to the controller when the full March C- sequence has been applied.

## Interface
- `ADDR_W`, default 4: memory address width; N = 2^ADDR_W words.
- `DATA_W`, default 8: memory data width.

- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous and active-low. Asserting `rst`=0 forces the reset state immediately.
- `ld` input 1: from the controller. When 1, arms the sequencer and clears its counters.
- `NbarT` input 1: from the controller. 1 means test mode, and operations are issued.
- `q_in` input DATA_W: memory read data, valid the cycle after `re`.
- `addr` output ADDR_W: memory address.
- `wdata` output DATA_W: memory write data, either all-0s or all-1s.
- `we` output 1: memory write strobe.
- `re` output 1: memory read strobe.
- `cout` output 1: one-cycle pulse when the sequence completes.
- `fail` output 1: sticky mismatch flag.
- `fail_addr` output ADDR_W: address of the first mismatch (diagnostic).
- `fail_elem` output 3: March element index of the first mismatch (diagnostic).

## Operation
- **States:** IDLE, RUN, DONE. `rst`=0 selects IDLE.
- **`ld` has priority** in every state. `ld`=1 moves to RUN and sets elem=0, op=0, and addr to the start address of element 0.
- **IDLE:** `NbarT` is ignored, and no operations are issued.
- **RUN with `NbarT`=1:** issue exactly one operation per cycle, then advance op, then addr, then elem.
- **RUN with `NbarT`=0:** pause. Counters hold and `we`/`re` stay 0.
- **Elements** (elem: direction, operations per address):
  - 0: ascending, w0
  - 1: ascending, r0 then w1
  - 2: ascending, r1 then w0
  - 3: descending, r0 then w1
  - 4: descending, r1 then w0
  - 5: ascending, r0
- **Data encoding:** "0" means all-0s and "1" means all-1s, for both `wdata` and the expected read value.
- **Address wrap:** ascending runs 0 to N-1 and descending runs N-1 to 0. At the end of an element, addr reloads to the next element's start address.
- **Completion:** after the last operation (elem 5, addr N-1), go to DONE. `cout`=1 in the following cycle only.
- **DONE:** `NbarT` is ignored and no operations are issued. Leave only via `ld` or reset.
- **Comparison:** each read registers its expected value and address. On the next cycle, if `q_in` differs from the expected value, `fail` is set to 1.
- **`fail` lifetime:** `fail` stays 1 through DONE and through `ld`. It is cleared only by reset or by the first issued operation of a run (elem 0, addr 0, op 0).
- **Diagnostic capture:** `fail_addr`/`fail_elem` capture the first mismatch only. Later mismatches do not overwrite them.
- **Reset mid-run:** all outputs return to reset values, and any in-flight comparison is discarded.

## Timing
- **Reset values:** `addr`=0, `wdata`=0, `we`=0, `re`=0, `cout`=0, `fail`=0, `fail_addr`=0, `fail_elem`=0.
- **Strobe outputs:** `addr`, `wdata`, `we` and `re` are combinational from registered state, gated by RUN && `NbarT` && !`ld`.
- **Latency:** a run takes 10N issued operations. `cout` rises in the cycle after the last issued operation, which is the cycle in which the final read's comparison is evaluated.
- **Controller handshake:** the controller samples `cout`=1 and drops `NbarT`/raises `ld` on the next edge. `fail` is already final when `cout`=1.
- **Pause mid-read:** if `NbarT` falls the cycle after a read, that read's comparison still happens that cycle.

## Configuration
- **`BIST_DIAG_EN` defined:** `fail_addr` and `fail_elem` capture the first mismatch as specified above.
- **`BIST_DIAG_EN` undefined:** no capture registers are built. `fail_addr` and `fail_elem` are tied to 0. The `fail` behaviour is unchanged.

## Test plan
All scenarios use ADDR_W=2 and DATA_W=8, against a behavioural memory with 1-cycle read latency.
- **Fault-free run:** `ld` pulse, then hold `NbarT`=1. Expect exactly 40 operations in the March C- order above and `cout` high for one cycle at cycle 41. Expect `fail`=0.
- **Stuck-at-0 fault:** stuck-at-0 on bit 3 of word 2. Expect the first mismatch at elem 2 (r1), addr 2, with `q_in`=0xF7. Expect `fail`=1, `fail_addr`=2, `fail_elem`=2, and `fail` still 1 after `cout` and the next `ld`.
- **Pause/resume:** drop `NbarT` for 5 cycles at operation 13. Expect `we`=`re`=0 during the pause, no skipped or repeated operation, and `cout` 5 cycles later than the fault-free run.
- **Async reset mid-run:** assert `rst`=0 mid-run (between clock edges) during elem 3. Expect all outputs at reset values immediately, with no clock edge required. After release, expect no operations until `ld`.
- **`ld` mid-run:** assert `ld` during elem 4. Expect a restart at elem 0, addr 0, and the full 40 operations to `cout`.
- **Diagnostics compiled out:** build without `BIST_DIAG_EN` and repeat the stuck-at-0 scenario. Expect `fail`=1 and `fail_addr`=`fail_elem`=0.
